// File: rtl/render_line_scheduler.sv
// Per-line launch of the layer0/layer1/sprite renderers and round-robin sharing
// of the VRAM render read port, with tag-routed read returns.
module render_line_scheduler #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_render_start,
  input  logic [8:0]        line_idx,
  input  logic              layer0_enabled,
  input  logic              layer1_enabled,
  input  logic              sprites_enabled,
  output logic [8:0]        render_line,
  output logic [2:0]        unit_start,
  input  logic [2:0]        unit_done,
  input  logic [2:0]        bus_req,
  input  logic [ADDR_W-1:0] bus_addr0,
  input  logic [ADDR_W-1:0] bus_addr1,
  input  logic [ADDR_W-1:0] bus_addr2,
  output logic [2:0]        bus_ack,
  output logic [31:0]       rddata,
  output logic [2:0]        rddata_valid,
  output logic              vram_strobe,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [31:0]       vram_rddata,
  output logic              busy,
  output logic              line_done,
  output logic [7:0]        overrun_count
);

  // state | meaning
  // IDLE  | no line in progress
  // RUN   | enabled units rendering and fetching
  // DRAIN | all active units done, waiting for in-flight reads
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [2:0]        active_mask;
  logic [2:0]        done_mask;
  logic [1:0]        rr_ptr;
  logic [2:0]        outstanding;
  logic [RD_LATENCY-1:0] tag_vld;
  logic [1:0]        tag_unit [RD_LATENCY];

  logic [2:0]        en_mask;
  logic [2:0]        eligible;
  logic [1:0]        cand0, cand1;
  logic [1:0]        grant_id;
  logic              grant_any;
  logic [ADDR_W-1:0] grant_addr;
  logic              ret;
  logic              retire;

  assign en_mask  = {sprites_enabled, layer1_enabled, layer0_enabled};
  assign eligible = (state == RUN) ? (bus_req & active_mask & ~done_mask) : 3'b000;
  assign ret      = tag_vld[RD_LATENCY-1];
  assign retire   = (state == DRAIN) && (outstanding == 3'd0);
  assign busy     = (state != IDLE);
  assign rddata   = vram_rddata;

  // Search order starts one past the last granted unit, wrapping mod 3.
  assign cand0 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
  assign cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = cand0;
    if (eligible[cand0]) begin
      grant_any = 1'b1;
      grant_id  = cand0;
    end else if (eligible[cand1]) begin
      grant_any = 1'b1;
      grant_id  = cand1;
    end else if (eligible[rr_ptr]) begin
      grant_any = 1'b1;
      grant_id  = rr_ptr;
    end
  end

  assign bus_ack = grant_any ? (3'b001 << grant_id) : 3'b000;

  always_comb begin
    case (grant_id)
      2'd0:    grant_addr = bus_addr0;
      2'd1:    grant_addr = bus_addr1;
      default: grant_addr = bus_addr2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      active_mask   <= '0;
      done_mask     <= '0;
      rr_ptr        <= 2'd2;
      outstanding   <= '0;
      tag_vld       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_unit[i] <= '0;
      render_line   <= '0;
      unit_start    <= '0;
      rddata_valid  <= '0;
      vram_strobe   <= 1'b0;
      vram_addr     <= '0;
      line_done     <= 1'b0;
      overrun_count <= '0;
    end else begin
      unit_start  <= '0;
      line_done   <= 1'b0;
      vram_strobe <= grant_any;
      if (grant_any) begin
        vram_addr <= grant_addr;
        rr_ptr    <= grant_id;
      end

      tag_vld[0]  <= grant_any;
      tag_unit[0] <= grant_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_unit[i] <= tag_unit[i-1];
      end
      rddata_valid <= ret ? (3'b001 << tag_unit[RD_LATENCY-1]) : 3'b000;

      case ({grant_any, ret})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        RUN: begin
          done_mask <= done_mask | (unit_done & active_mask);
          if (((done_mask | unit_done) & active_mask) == active_mask) state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == 3'd0) begin
            line_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      // A start that lands on the final drain cycle is a clean hand-off, not an overrun.
      if (line_render_start) begin
        if ((state != IDLE) && !retire) begin
          if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
          tag_vld      <= '0;
          outstanding  <= '0;
          rddata_valid <= '0;
        end
        active_mask <= en_mask;
        render_line <= line_idx;
        done_mask   <= '0;
        unit_start  <= en_mask;
        state       <= (en_mask != 3'b000) ? RUN : DRAIN;
      end
    end
  end

endmodule
